alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
- Micro-sequencer that owns the 8x16 register file and the ALU.
- Fetches 16-bit instructions from a small synchronous program ROM, drives ALU operands and controls, and writes results and flags back.
- Runs the program once per video frame, started by the rising edge of vga_v_sync. Register contents are therefore updated per frame and shown by the register-to-pixel display path.

Parameters:
PC_W, 8, program counter / ROM address width
OP_W, 4, ALU operation code width

Ports:
clk  in  1  pixel clock (PLL output)
rst_n  in  1  asynchronous active-low reset
vga_v_sync  in  1  vertical sync level; sequencer detects its rising edge
rom_addr  out  PC_W  program ROM address
rom_data  in  16  ROM data, valid the cycle after rom_addr
rd_addr_a  out  3  register file read address A (combinational read)
rd_addr_b  out  3  register file read address B
rd_data_a  in  16  register A data
rd_data_b  in  16  register B data
operand1  out  16  ALU operand 1
operand2  out  16  ALU operand 2
alu_operation  out  OP_W  ALU operation code
enable_alu  out  1  ALU logic/arith enable
enable_shift  out  1  ALU shift enable
enable_load  out  1  ALU load enable
carry_in  out  1  stored carry flag fed to ALU
alu_result  in  16  ALU result
alu_carry_out  in  1  ALU carry flag
alu_zero_out  in  1  ALU zero flag
alu_negative_out  in  1  ALU negative flag
wr_en  out  1  register write strobe, one cycle
wr_addr  out  3  register write address
wr_data  out  16  register write data
busy  out  1  high while the program executes
overrun  out  1  one-cycle pulse when a frame edge arrives while busy

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE; pc=0; flags C/Z/N=0; pending=0.
  - All outputs 0: wr_en=0, busy=0, overrun=0, enable_*=0.
  - An in-flight instruction is dropped with no write.
- Frame edge: vga_v_sync is registered twice; edge = sync2 & ~sync3, so it takes effect 3 clk after the pin rises.
- Instruction fields:
  - [15:13] class
  - [12:10] rd
  - [9:7] rs1
  - [6:4] rs2
  - [3:0] aluop (OP_W low bits)
  - [7:0] imm8
- Classes:
  - 000 ALU: rd = ALU(rs1, rs2); enable_alu=1.
  - 001 SHIFT: as ALU with enable_shift=1, enable_alu=0.
  - 010 LDI: rd = {8'h00, imm8}; bypasses the ALU; flags unchanged.
  - 011 BZ: if Z then pc = pc + sext(imm8), else pc+1.
  - 100 BRA: pc = pc + sext(imm8).
  - 101 WAITF: end of program; go to WAIT.
  - 11x NOP.
- States, 4 clk per instruction; branches and NOP skip WB and go straight to FETCH:
  - IDLE: busy=0; on edge go to FETCH with pc=0.
  - FETCH: rom_addr=pc; go to DECODE.
  - DECODE: latch rom_data into the instruction register; drive rd_addr_a=rs1, rd_addr_b=rs2; go to EXEC.
  - EXEC:
    - operand1=rd_data_a, operand2=rd_data_b, carry_in=C, alu_operation=aluop, enable_* per class.
    - Latch alu_result and flags into holding registers.
    - Branches update pc here.
  - WB: wr_en=1 for one cycle with wr_addr=rd and wr_data=held value. For ALU/SHIFT only, C/Z/N take the held flags. pc=pc+1; go to FETCH.
  - WAIT: busy=0. If pending=1, clear it and go to FETCH with pc=0 in the next cycle. Otherwise stay until an edge arrives, then go to FETCH with pc=0.
- enable_* and operand1/2 are zero outside EXEC.
- busy=1 in FETCH/DECODE/EXEC/WB.
- pc arithmetic is modulo 2^PC_W: wraps from all-ones to 0; negative offsets wrap likewise.
- Edge while busy:
  - overrun pulses for one cycle.
  - pending is set; it saturates at one, so extra edges are lost.
  - Execution continues uninterrupted.
- Edge in the same cycle as the WB→WAIT decision: counts as pending; WAIT then restarts immediately.
- The register file is written only via wr_en; at most one write per instruction.

Test Plan:
- Reset mid-EXEC of ALU op → wr_en never asserts, all outputs 0 while rst_n=0, IDLE after release, no activity until the next vga_v_sync rise.
- Program LDI r1,0x05; LDI r2,0x03; ALU r3=r1 AND r2; WAITF → writes (1,0x0005), (2,0x0003), (3,0x0001).
  - wr_en pulses exactly 3 times.
  - First FETCH occurs 3 clk after vga_v_sync rises.
  - busy=0 after WAITF.
- LDI r1,0; ALU r1 = r1 AND r1 (Z=1); BZ +2; LDI r4,0xAA; LDI r5,0x55; WAITF → r4 is not written, r5=0x0055.
  - With alu_zero_out forced to 0, r4=0x00AA is written.
- Program of BRA 0 (infinite loop), second vga_v_sync edge → overrun pulses exactly 1 cycle and busy stays 1.
  - Third edge → overrun pulses again; pending stays 1, not 2.
- pc wrap with PC_W=3: NOPs at 0..7, WAITF at 0 after wrap → execution passes address 7 then fetches address 0 and stops in WAIT.
- ALU op with alu_carry_out=1, then a second ALU op → carry_in=1 during the second EXEC. An intervening LDI leaves C unchanged.

Source files
------------

// File: rtl/alu_sequencer.sv
// Per-frame micro-sequencer: fetches from a synchronous ROM, drives the ALU and writes results to the register file.
// 4 clk per instruction (3 for branches/NOP/WAITF); no backpressure, frame edges arriving while busy set pending and pulse overrun.
module alu_sequencer #(
  parameter int PC_W = 8,
  parameter int OP_W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            vga_v_sync,
  output logic [PC_W-1:0] rom_addr,
  input  logic [15:0]     rom_data,
  output logic [2:0]      rd_addr_a,
  output logic [2:0]      rd_addr_b,
  input  logic [15:0]     rd_data_a,
  input  logic [15:0]     rd_data_b,
  output logic [15:0]     operand1,
  output logic [15:0]     operand2,
  output logic [OP_W-1:0] alu_operation,
  output logic            enable_alu,
  output logic            enable_shift,
  output logic            enable_load,
  output logic            carry_in,
  input  logic [15:0]     alu_result,
  input  logic            alu_carry_out,
  input  logic            alu_zero_out,
  input  logic            alu_negative_out,
  output logic            wr_en,
  output logic [2:0]      wr_addr,
  output logic [15:0]     wr_data,
  output logic            busy,
  output logic            overrun
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_WAIT
  } state_t;

  localparam logic [2:0] CL_ALU   = 3'b000;
  localparam logic [2:0] CL_SHIFT = 3'b001;
  localparam logic [2:0] CL_LDI   = 3'b010;
  localparam logic [2:0] CL_BZ    = 3'b011;
  localparam logic [2:0] CL_BRA   = 3'b100;
  localparam logic [2:0] CL_WAITF = 3'b101;

  state_t          state, state_nxt;
  logic [PC_W-1:0] pc, pc_nxt, pc_inc, pc_rel;
  logic [15:0]     ir, hold, off16;
  logic [2:0]      cls;
  logic            c_flag, z_flag, n_flag;
  logic            hold_c, hold_z, hold_n;
  logic            pending, sync1, sync2, sync3, frame_edge, run;

  assign cls        = ir[15:13];
  assign frame_edge = sync2 & ~sync3;
  assign run        = (state == S_FETCH) || (state == S_DECODE) ||
                      (state == S_EXEC)  || (state == S_WB);
  assign busy       = run;
  assign overrun    = frame_edge & run;
  // Sign-extend then truncate: gives modulo-2^PC_W relative jumps for any PC_W <= 16.
  assign off16      = {{8{ir[7]}}, ir[7:0]};
  assign pc_inc     = pc + PC_W'(1);
  assign pc_rel     = pc + off16[PC_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      pc      <= '0;
      ir      <= '0;
      hold    <= '0;
      hold_c  <= 1'b0;
      hold_z  <= 1'b0;
      hold_n  <= 1'b0;
      c_flag  <= 1'b0;
      z_flag  <= 1'b0;
      n_flag  <= 1'b0;
      pending <= 1'b0;
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      sync3   <= 1'b0;
    end else begin
      {sync3, sync2, sync1} <= {sync2, sync1, vga_v_sync};
      state <= state_nxt;
      pc    <= pc_nxt;
      if (state == S_DECODE) ir <= rom_data;
      if (state == S_EXEC) begin
        hold   <= (cls == CL_LDI) ? {8'h00, ir[7:0]} : alu_result;
        hold_c <= alu_carry_out;
        hold_z <= alu_zero_out;
        hold_n <= alu_negative_out;
      end
      if (state == S_WB && (cls == CL_ALU || cls == CL_SHIFT)) begin
        c_flag <= hold_c;
        z_flag <= hold_z;
        n_flag <= hold_n;
      end
      if (state == S_WAIT && pending) pending <= 1'b0;
      else if (overrun)               pending <= 1'b1;
    end
  end

  always_comb begin
    state_nxt     = state;
    pc_nxt        = pc;
    rom_addr      = pc;
    rd_addr_a     = ir[9:7];
    rd_addr_b     = ir[6:4];
    operand1      = '0;
    operand2      = '0;
    alu_operation = '0;
    enable_alu    = 1'b0;
    enable_shift  = 1'b0;
    // LDI bypasses the ALU, so the load enable is never raised.
    enable_load   = 1'b0;
    carry_in      = 1'b0;
    wr_en         = 1'b0;
    wr_addr       = '0;
    wr_data       = '0;
    case (state)
      S_IDLE: begin
        if (frame_edge) begin
          state_nxt = S_FETCH;
          pc_nxt    = '0;
        end
      end
      S_FETCH: state_nxt = S_DECODE;
      S_DECODE: begin
        rd_addr_a = rom_data[9:7];
        rd_addr_b = rom_data[6:4];
        state_nxt = S_EXEC;
      end
      S_EXEC: begin
        operand1      = rd_data_a;
        operand2      = rd_data_b;
        carry_in      = c_flag;
        alu_operation = ir[OP_W-1:0];
        case (cls)
          CL_ALU: begin
            enable_alu = 1'b1;
            state_nxt  = S_WB;
          end
          CL_SHIFT: begin
            enable_shift = 1'b1;
            state_nxt    = S_WB;
          end
          CL_LDI:   state_nxt = S_WB;
          CL_BZ: begin
            pc_nxt    = z_flag ? pc_rel : pc_inc;
            state_nxt = S_FETCH;
          end
          CL_BRA: begin
            pc_nxt    = pc_rel;
            state_nxt = S_FETCH;
          end
          CL_WAITF: state_nxt = S_WAIT;
          default: begin
            pc_nxt    = pc_inc;
            state_nxt = S_FETCH;
          end
        endcase
      end
      S_WB: begin
        wr_en     = 1'b1;
        wr_addr   = ir[12:10];
        wr_data   = hold;
        pc_nxt    = pc_inc;
        state_nxt = S_FETCH;
      end
      S_WAIT: begin
        if (pending || frame_edge) begin
          state_nxt = S_FETCH;
          pc_nxt    = '0;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: reference model queues expected writes/EXEC cycles, a forked monitor pops and compares.
// Second instance with PC_W=3 exercises program-counter wrap.
module tb_alu_sequencer;

  logic clk = 1'b0, rst_n = 1'b0, vga_v_sync = 1'b0, vsync2 = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  rom_addr;
  logic [15:0] rom_data, rd_data_a, rd_data_b, operand1, operand2, alu_result, wr_data;
  logic [2:0]  rd_addr_a, rd_addr_b, wr_addr;
  logic [3:0]  alu_operation;
  logic enable_alu, enable_shift, enable_load, carry_in, alu_carry_out, alu_zero_out;
  logic alu_negative_out, wr_en, busy, overrun;

  logic [2:0]  rom_addr2, rd_addr_a2, rd_addr_b2, wr_addr2;
  logic [15:0] rom_data2, operand1_2, operand2_2, wr_data2;
  logic [3:0]  alu_operation2;
  logic enable_alu2, enable_shift2, enable_load2, carry_in2, wr_en2, busy2, overrun2;

  logic [15:0] rom [256];
  logic [15:0] rom2 [8];
  logic [15:0] rf [8] = '{default: 16'h0000};
  logic force_z0 = 1'b0;

  localparam logic [15:0] WAITF = 16'hA000;
  localparam logic [15:0] NOP   = 16'hC000;

  // Bench ALU: 0 AND, 1 OR, 2 XOR, 3 ADD+cin, 4 SUB (carry=borrow), else pass A; shift op[0]=1 SHR else SHL.
  function automatic logic [18:0] alu_f(input logic [15:0] a, input logic [15:0] b,
                                        input logic [3:0] op, input logic cin,
                                        input logic sh, input logic fz);
    logic [16:0] t;
    logic [15:0] r;
    logic c;
    c = 1'b0;
    if (sh) begin
      if (op[0]) begin r = a >> 1; c = a[0]; end
      else       begin r = a << 1; c = a[15]; end
    end else begin
      case (op)
        4'd0: r = a & b;
        4'd1: r = a | b;
        4'd2: r = a ^ b;
        4'd3: begin t = {1'b0, a} + {1'b0, b} + {16'h0, cin}; r = t[15:0]; c = t[16]; end
        4'd4: begin r = a - b; c = (a < b); end
        default: r = a;
      endcase
    end
    return {c, (r == 16'h0) && !fz, r[15], r};
  endfunction

  always @(posedge clk) rom_data  <= rom[rom_addr];
  always @(posedge clk) rom_data2 <= rom2[rom_addr2];
  always @(posedge clk) if (wr_en) rf[wr_addr] <= wr_data;
  assign rd_data_a = rf[rd_addr_a];
  assign rd_data_b = rf[rd_addr_b];
  always_comb {alu_carry_out, alu_zero_out, alu_negative_out, alu_result} =
    alu_f(operand1, operand2, alu_operation, carry_in, enable_shift, force_z0);

  alu_sequencer #(.PC_W(8), .OP_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .vga_v_sync(vga_v_sync), .rom_addr(rom_addr), .rom_data(rom_data),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .operand1(operand1), .operand2(operand2), .alu_operation(alu_operation),
    .enable_alu(enable_alu), .enable_shift(enable_shift), .enable_load(enable_load),
    .carry_in(carry_in), .alu_result(alu_result), .alu_carry_out(alu_carry_out),
    .alu_zero_out(alu_zero_out), .alu_negative_out(alu_negative_out), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .overrun(overrun));

  alu_sequencer #(.PC_W(3), .OP_W(4)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .vga_v_sync(vsync2), .rom_addr(rom_addr2), .rom_data(rom_data2),
    .rd_addr_a(rd_addr_a2), .rd_addr_b(rd_addr_b2), .rd_data_a(16'h0000), .rd_data_b(16'h0000),
    .operand1(operand1_2), .operand2(operand2_2), .alu_operation(alu_operation2),
    .enable_alu(enable_alu2), .enable_shift(enable_shift2), .enable_load(enable_load2),
    .carry_in(carry_in2), .alu_result(16'h0000), .alu_carry_out(1'b0),
    .alu_zero_out(1'b0), .alu_negative_out(1'b0), .wr_en(wr_en2),
    .wr_addr(wr_addr2), .wr_data(wr_data2), .busy(busy2), .overrun(overrun2));

  int n_chk = 0, n_pass = 0;
  int wr_cnt = 0, ov_cyc = 0, ov_rise = 0;
  logic ov_prev = 1'b0, sb_on = 1'b1;
  logic [18:0] wq [$];
  logic [38:0] eq [$];
  logic [15:0] m_regs [8];
  logic mc = 1'b0, mz = 1'b0, mn = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [15:0] i_alu(input logic [2:0] rd, input logic [2:0] s1,
                                        input logic [2:0] s2, input logic [3:0] op);
    return {3'b000, rd, s1, s2, op};
  endfunction
  function automatic logic [15:0] i_ldi(input logic [2:0] rd, input logic [7:0] imm);
    return {3'b010, rd, 2'b00, imm};
  endfunction
  function automatic logic [15:0] i_bz(input logic [7:0] off);
    return {3'b011, 5'b00000, off};
  endfunction

  function automatic logic [15:0] rand_ins();
    case ($urandom_range(0, 5))
      0: return {3'b000, 13'($urandom())};
      1: return {3'b001, 13'($urandom())};
      2, 3: return i_ldi(3'($urandom()), 8'($urandom()));
      4: return {2'b11, 14'($urandom())};
      default: return i_bz(8'($urandom_range(1, 3)));
    endcase
  endfunction

  task automatic fill_rom();
    for (int i = 0; i < 256; i++) rom[i] = WAITF;
  endtask

  // Executes the ROM program instruction by instruction and queues what the DUT must show.
  task automatic run_model();
    logic [7:0]  pc;
    logic [15:0] ins;
    logic [18:0] v;
    pc = 8'd0;
    for (int s = 0; s < 1000; s++) begin
      ins = rom[pc];
      case (ins[15:13])
        3'd0, 3'd1: begin
          v = alu_f(m_regs[ins[9:7]], m_regs[ins[6:4]], ins[3:0], mc, ins[13], force_z0);
          eq.push_back({~ins[13], ins[13], ins[3:0], mc, m_regs[ins[9:7]], m_regs[ins[6:4]]});
          wq.push_back({ins[12:10], v[15:0]});
          m_regs[ins[12:10]] = v[15:0];
          {mc, mz, mn} = v[18:16];
          pc = pc + 8'd1;
        end
        3'd2: begin
          wq.push_back({ins[12:10], 8'h00, ins[7:0]});
          m_regs[ins[12:10]] = {8'h00, ins[7:0]};
          pc = pc + 8'd1;
        end
        3'd3: pc = mz ? pc + ins[7:0] : pc + 8'd1;
        3'd4: pc = pc + ins[7:0];
        3'd5: return;
        default: pc = pc + 8'd1;
      endcase
    end
  endtask

  task automatic frame();
    @(posedge clk); #1 vga_v_sync = 1'b1;
    repeat (4) @(posedge clk);
    #1 vga_v_sync = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && busy; i++) @(negedge clk);
    chk("frame_done", busy, 0);
    repeat (3) @(negedge clk);
    chk("wq_drained", wq.size(), 0);
    chk("eq_drained", eq.size(), 0);
  endtask

  task automatic chk_outs_zero(input string nm);
    chk({nm, "_a"}, {rom_addr, rd_addr_a, rd_addr_b, operand1, operand2}, 0);
    chk({nm, "_b"}, {alu_operation, enable_alu, enable_shift, enable_load, carry_in,
                     wr_en, wr_addr, wr_data, busy, overrun}, 0);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int wc0, o0, r0, low, rises, trans, bad;
    logic prev_b, started;
    logic [2:0] prev_a;

    fork
      forever begin
        @(negedge clk);
        if (wr_en) wr_cnt++;
        if (rst_n) begin
          if (wr_en) begin
            if (wq.size() == 0) begin
              n_chk++;
              $display("FAIL unexpected_write: got %0h, expected no write", {wr_addr, wr_data});
            end else chk("write", {wr_addr, wr_data}, wq.pop_front());
          end
          if (sb_on && (enable_alu || enable_shift)) begin
            if (eq.size() == 0) begin
              n_chk++;
              $display("FAIL unexpected_exec: got %0h, expected no ALU cycle", operand1);
            end else chk("exec", {enable_alu, enable_shift, alu_operation, carry_in, operand1, operand2},
                         eq.pop_front());
          end
          if (overrun) begin
            ov_cyc++;
            if (!ov_prev) ov_rise++;
          end
          ov_prev = overrun;
        end
      end
    join_none

    fill_rom();
    for (int i = 0; i < 8; i++) begin rom2[i] = NOP; m_regs[i] = 16'h0000; end

    repeat (3) @(posedge clk);
    #1 chk_outs_zero("reset_outs");
    chk("reset_outs2_a", {rom_addr2, rd_addr_a2, rd_addr_b2, operand1_2, operand2_2}, 0);
    chk("reset_outs2_b", {alu_operation2, enable_alu2, enable_shift2, enable_load2, carry_in2,
                          wr_en2, wr_addr2, wr_data2, busy2, overrun2}, 0);
    @(negedge clk) rst_n = 1'b1;

    // Reset landing in the EXEC cycle of an ALU op must drop the write.
    sb_on = 1'b0;
    rom[0] = i_alu(3'd3, 3'd1, 3'd2, 4'd0);
    frame();
    for (int i = 0; i < 20 && !enable_alu; i++) @(negedge clk);
    chk("rst_exec_seen", enable_alu, 1);
    rst_n = 1'b0;
    #1 chk_outs_zero("rst_mid_exec");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("rst_idle_busy", busy, 0);
    chk("rst_no_write", wr_cnt, 0);
    sb_on = 1'b1;

    // LDI/LDI/AND with first-fetch timing.
    fill_rom();
    rom[0] = i_ldi(3'd1, 8'h05); rom[1] = i_ldi(3'd2, 8'h03);
    rom[2] = i_alu(3'd3, 3'd1, 3'd2, 4'd0);
    run_model();
    wc0 = wr_cnt;
    @(posedge clk); #1 vga_v_sync = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk("fetch_not_yet", busy, 0);
    @(posedge clk);
    #1 chk("fetch_at_3clk", {busy, rom_addr}, {1'b1, 8'h00});
    @(posedge clk); #1 vga_v_sync = 1'b0;
    wait_done(200);
    chk("ldi_write_count", wr_cnt - wc0, 3);
    chk("ldi_r3", rf[3], 16'h0001);

    // BZ taken skips r4; with Z forced low it falls through.
    fill_rom();
    rom[0] = i_ldi(3'd1, 8'h00); rom[1] = i_alu(3'd1, 3'd1, 3'd1, 4'd0);
    rom[2] = i_bz(8'd2); rom[3] = i_ldi(3'd4, 8'hAA); rom[4] = i_ldi(3'd5, 8'h55);
    run_model();
    frame();
    wait_done(200);
    chk("bz_r4_skipped", rf[4], 16'h0000);
    chk("bz_r5", rf[5], 16'h0055);
    force_z0 = 1'b1;
    run_model();
    frame();
    wait_done(200);
    chk("bz_r4_fallthru", rf[4], 16'h00AA);
    force_z0 = 1'b0;

    // Carry from SUB survives an LDI and feeds the next ADD.
    fill_rom();
    rom[0] = i_ldi(3'd0, 8'h00); rom[1] = i_ldi(3'd2, 8'h01);
    rom[2] = i_alu(3'd3, 3'd0, 3'd2, 4'd4); rom[3] = i_ldi(3'd6, 8'h07);
    rom[4] = i_alu(3'd4, 3'd0, 3'd0, 4'd3);
    run_model();
    frame();
    wait_done(200);
    chk("carry_sub_r3", rf[3], 16'hFFFF);
    chk("carry_add_r4", rf[4], 16'h0001);

    for (int f = 0; f < 8; f++) begin
      fill_rom();
      for (int i = 0; i < 12; i++) rom[i] = rand_ins();
      run_model();
      frame();
      wait_done(400);
    end

    // Infinite loop: extra edges pulse overrun and leave a single pending restart.
    fill_rom();
    rom[0] = 16'h8000;
    frame();
    repeat (10) @(negedge clk);
    o0 = ov_cyc; r0 = ov_rise;
    frame();
    low = 0;
    repeat (10) begin @(negedge clk); if (!busy) low++; end
    chk("ovr1_cycles", ov_cyc - o0, 1);
    chk("ovr1_pulses", ov_rise - r0, 1);
    frame();
    repeat (10) begin @(negedge clk); if (!busy) low++; end
    chk("ovr2_cycles", ov_cyc - o0, 2);
    chk("ovr2_pulses", ov_rise - r0, 2);
    chk("ovr_busy_low_cycles", low, 0);
    rom[0] = WAITF;
    rises = 0; prev_b = busy;
    repeat (80) begin
      @(negedge clk);
      if (busy && !prev_b) rises++;
      prev_b = busy;
    end
    chk("pending_restart_once", rises, 1);
    chk("pending_end_idle", busy, 0);

    // PC_W=3 instance: NOPs walk 0..7, wrap to 0 where WAITF now sits.
    @(posedge clk); #1 vsync2 = 1'b1;
    repeat (4) @(posedge clk);
    #1 vsync2 = 1'b0;
    trans = 0; bad = 0; started = 1'b0; prev_a = rom_addr2;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (busy2) started = 1'b1;
      if (rom_addr2 != prev_a) begin
        trans++;
        if (rom_addr2 != prev_a + 3'd1) bad++;
        prev_a = rom_addr2;
      end
      if (rom_addr2 == 3'd1) rom2[0] = WAITF;
      if (started && !busy2) break;
    end
    chk("wrap_started", started, 1);
    chk("wrap_transitions", trans, 8);
    chk("wrap_bad_steps", bad, 0);
    chk("wrap_end", {busy2, rom_addr2}, {1'b0, 3'b000});

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
